// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, LSB-first data, optional parity, stop bit.
// One bit per clock; the clock is the baud clock.
module uart_tx_frame #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Data_valid,
    input  logic [width-1:0] P_data,
    input  logic             Par_type,
    input  logic             Par_en,
    output logic             Busy,
    output logic             TX_out
);

    localparam int CNT_W = (width > 1) ? $clog2(width) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(width - 1);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        START  = 4'd1,
        DATA   = 4'd2,
        PARITY = 4'd3,
        STOP   = 4'd4
    } state_t;

    state_t             state_r;
    logic [width-1:0]   data_r;
    logic               par_en_r;
    logic               par_type_r;
    logic [CNT_W-1:0]   bit_cnt_r;
    logic               parity_s;

    // Even parity is the XOR of the data; odd parity is its complement.
    function automatic logic parity_calc(input logic [width-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    // Controller: frame sequencing and latching of the word and its parity config.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            data_r     <= {width{1'b0}};
            par_en_r   <= 1'b0;
            par_type_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (Data_valid) begin
                        state_r    <= START;
                        data_r     <= P_data;
                        par_en_r   <= Par_en;
                        par_type_r <= Par_type;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START:  state_r <= DATA;
                DATA: begin
                    if (bit_cnt_r == LAST_BIT) begin
                        state_r <= par_en_r ? PARITY : STOP;
                    end else begin
                        state_r <= DATA;
                    end
                end
                PARITY: state_r <= STOP;
                STOP:   state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Serializer: selects the data bit on the line; held at zero outside DATA.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == DATA) begin
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
        end else begin
            bit_cnt_r <= {CNT_W{1'b0}};
        end
    end

    assign parity_s = parity_calc(data_r, par_type_r);

    // Output mux: line level and busy flag decoded from the current state.
    always_comb begin
        TX_out = 1'b1;
        Busy   = 1'b0;
        case (state_r)
            IDLE: begin
                TX_out = 1'b1;
                Busy   = 1'b0;
            end
            START: begin
                TX_out = 1'b0;
                Busy   = 1'b1;
            end
            DATA: begin
                TX_out = data_r[bit_cnt_r];
                Busy   = 1'b1;
            end
            PARITY: begin
                TX_out = parity_s;
                Busy   = 1'b1;
            end
            STOP: begin
                TX_out = 1'b1;
                Busy   = 1'b1;
            end
            default: begin
                TX_out = 1'b1;
                Busy   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: directed frames plus random traffic
// compared against a frame-queue reference model.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       Data_valid = 1'b0;
    logic [7:0] P_data = 8'h00;
    logic       Par_type = 1'b0;
    logic       Par_en = 1'b0;
    logic       Busy;
    logic       TX_out;

    int errors = 0;
    int checks = 0;

    // Reference model: the bits still to appear on the line, front = current bit.
    bit   model_q[$];
    logic exp_busy = 1'b0;
    logic exp_tx = 1'b1;

    uart_tx_frame #(.width(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .Data_valid (Data_valid),
        .P_data     (P_data),
        .Par_type   (Par_type),
        .Par_en     (Par_en),
        .Busy       (Busy),
        .TX_out     (TX_out)
    );

    always #5 clk = ~clk;

    task automatic tick(input logic dv, input logic [7:0] d, input logic pe, input logic pt);
        @(negedge clk);
        Data_valid = dv;
        P_data     = d;
        Par_en     = pe;
        Par_type   = pt;
        @(posedge clk);
        if (!rst) begin
            model_q.delete();
        end else if (model_q.size() != 0) begin
            void'(model_q.pop_front());
        end else if (dv) begin
            int ones = 0;
            model_q.push_back(1'b0);
            for (int i = 0; i < 8; i++) begin
                model_q.push_back(d[i]);
                ones += int'(d[i]);
            end
            if (pe) model_q.push_back(pt ? (ones % 2 == 0) : (ones % 2 == 1));
            model_q.push_back(1'b1);
        end
        exp_busy = (model_q.size() != 0);
        exp_tx   = exp_busy ? model_q[0] : 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (TX_out !== 1'b1 || Busy !== 1'b0 || dut.state_r !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold: tx=%b busy=%b state=%0d expected tx=1 busy=0 state=0", TX_out, Busy, dut.state_r);
        end
        @(negedge clk);
        rst = 1'b1;
        model_q.delete();
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (TX_out !== 1'b1 || Busy !== 1'b0 || dut.state_r !== 4'd0) begin
            errors++;
            $display("FAIL reset_release: tx=%b busy=%b state=%0d expected tx=1 busy=0 state=0", TX_out, Busy, dut.state_r);
        end
    endtask

    task automatic test_even_parity();
        logic seq [0:10];
        seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tick(1'b1, 8'b10011010, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (TX_out !== seq[i] || Busy !== 1'b1) begin
                errors++;
                $display("FAIL even_bit%0d: tx=%b busy=%b expected tx=%b busy=1", i, TX_out, Busy, seq[i]);
            end
            tick(1'b0, 8'h00, 1'b0, 1'b0);
        end
        checks++;
        if (TX_out !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL even_end: tx=%b busy=%b expected tx=1 busy=0", TX_out, Busy);
        end
    endtask

    task automatic test_odd_parity();
        logic seq [0:10];
        seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tick(1'b1, 8'hA5, 1'b1, 1'b1);
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (TX_out !== seq[i] || Busy !== 1'b1) begin
                errors++;
                $display("FAIL odd_bit%0d: tx=%b busy=%b expected tx=%b busy=1", i, TX_out, Busy, seq[i]);
            end
            tick(1'b0, 8'h00, 1'b0, 1'b0);
        end
        checks++;
        if (TX_out !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL odd_end: tx=%b busy=%b expected tx=1 busy=0", TX_out, Busy);
        end
    endtask

    task automatic test_no_parity();
        logic seq [0:9];
        seq = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tick(1'b1, 8'h0F, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (TX_out !== seq[i] || Busy !== 1'b1 || dut.state_r === 4'd3) begin
                errors++;
                $display("FAIL nopar_bit%0d: tx=%b busy=%b state=%0d expected tx=%b busy=1 state!=3", i, TX_out, Busy, dut.state_r, seq[i]);
            end
            tick(1'b0, 8'h00, 1'b0, 1'b0);
        end
        checks++;
        if (TX_out !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL nopar_end: tx=%b busy=%b expected tx=1 busy=0", TX_out, Busy);
        end
    endtask

    task automatic test_busy_protect();
        tick(1'b1, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (TX_out !== exp_tx || Busy !== exp_busy) begin
                errors++;
                $display("FAIL busy_protect_cyc%0d: tx=%b busy=%b expected tx=%b busy=%b", i, TX_out, Busy, exp_tx, exp_busy);
            end
            if (i == 4) tick(1'b1, 8'hFF, 1'b1, 1'b1);
            else tick(1'b0, 8'($urandom), 1'b1, 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (TX_out !== 1'b1 || Busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_line%0d: tx=%b busy=%b expected tx=1 busy=0", i, TX_out, Busy);
            end
            tick(1'b0, 8'hFF, 1'b0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 34; i++) begin
            tick(1'b1, 8'h81, 1'b1, 1'b0);
            checks++;
            if (TX_out !== exp_tx || Busy !== exp_busy) begin
                errors++;
                $display("FAIL b2b_cyc%0d: tx=%b busy=%b expected tx=%b busy=%b", i, TX_out, Busy, exp_tx, exp_busy);
            end
        end
        for (int i = 0; i < 12; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        tick(1'b1, 8'hC3, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (TX_out !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: tx=%b busy=%b expected tx=1 busy=0", TX_out, Busy);
        end
        model_q.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 8'h00, 1'b0, 1'b0);
            checks++;
            if (TX_out !== 1'b1 || Busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_after%0d: tx=%b busy=%b expected tx=1 busy=0", i, TX_out, Busy);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) begin
            tick(($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom), 1'($urandom));
            checks++;
            if (TX_out !== exp_tx || Busy !== exp_busy) begin
                errors++;
                $display("FAIL random_cyc%0d: tx=%b busy=%b expected tx=%b busy=%b", i, TX_out, Busy, exp_tx, exp_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_no_parity();
        test_busy_protect();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
